vga_tile_scanner: RTL



---
 rtl/vga_timing_pkg.sv | 47 ++++
 rtl/vga_sync_counter.sv | 76 +++++++
 rtl/vga_tile_scanner.sv | 126 ++++++++++++
 3 files changed

// File: rtl/vga_timing_pkg.sv
// Shared 640x480@60 raster timing, tile geometry and RGB222 constants for the
// tile scanner and the colour layers that feed it.
package vga_timing_pkg;

  localparam int unsigned H_ACTIVE     = 640;
  localparam int unsigned H_FP         = 16;
  localparam int unsigned H_SYNC       = 96;
  localparam int unsigned H_BP         = 48;
  localparam int unsigned H_TOTAL      = H_ACTIVE + H_FP + H_SYNC + H_BP;

  localparam int unsigned V_ACTIVE     = 480;
  localparam int unsigned V_FP         = 10;
  localparam int unsigned V_SYNC       = 2;
  localparam int unsigned V_BP         = 33;
  localparam int unsigned V_TOTAL      = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam int unsigned TILE_W       = 10;
  localparam int unsigned TILE_H_SHIFT = 4;

  localparam int unsigned POS_W        = 10;
  localparam int unsigned TPX_W        = 4;
  localparam int unsigned X_W          = 6;
  localparam int unsigned Y_W          = 5;
  localparam int unsigned RGB_W        = 6;

  typedef logic [RGB_W-1:0] rgb222_t;

  localparam rgb222_t RGB_BLACK = 6'h00;
  localparam rgb222_t RGB_WHITE = 6'h3f;

  typedef struct packed {
    logic de;
    logic hsync_n;
    logic vsync_n;
    logic frame_tick;
  } sync_t;

  localparam sync_t SYNC_IDLE = '{de: 1'b0, hsync_n: 1'b1, vsync_n: 1'b1, frame_tick: 1'b0};

  // True when pos lies in the half-open window [lo, lo+len).
  function automatic logic in_window(input logic [POS_W-1:0] pos,
                                     input int unsigned lo,
                                     input int unsigned len);
    return (pos >= POS_W'(lo)) && (pos < POS_W'(lo + len));
  endfunction

endpackage

// File: rtl/vga_sync_counter.sv
// Raster position counters, tile-row register, and the registered sync/de/frame_tick decode.
// SCAN_SCROLL_EN adds the frame_end_c strobe port used by the scroll register.
module vga_sync_counter
  import vga_timing_pkg::*;
#(
  parameter int unsigned V_ACTIVE_CFG = V_ACTIVE,
  parameter int unsigned V_FP_CFG     = V_FP,
  parameter int unsigned V_SYNC_CFG   = V_SYNC,
  parameter int unsigned V_BP_CFG     = V_BP
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             pix_en,
  output logic [POS_W-1:0] hpos,
  output logic [Y_W-1:0]   y,
  output sync_t            sync,
  output logic             line_end_c,
  output logic             active_c
`ifdef SCAN_SCROLL_EN
  ,
  output logic             frame_end_c
`endif
);

  localparam int unsigned V_TOTAL_CFG = V_ACTIVE_CFG + V_FP_CFG + V_SYNC_CFG + V_BP_CFG;

`ifndef SCAN_SCROLL_EN
  logic frame_end_c;
`endif

  logic [POS_W-1:0] hpos_q, hpos_d;
  logic [POS_W-1:0] vpos_q, vpos_d;
  logic [Y_W-1:0]   y_q, y_d;
  sync_t            sync_q, sync_d;

  // Next-state for counters; the pin decode looks at the current position.
  always_comb begin
    line_end_c  = (hpos_q == POS_W'(H_TOTAL - 1));
    frame_end_c = line_end_c && (vpos_q == POS_W'(V_TOTAL_CFG - 1));
    active_c    = (hpos_q < POS_W'(H_ACTIVE)) && (vpos_q < POS_W'(V_ACTIVE_CFG));
    hpos_d      = hpos_q;
    vpos_d      = vpos_q;
    y_d         = y_q;
    sync_d      = sync_q;
    if (pix_en) begin
      hpos_d = line_end_c ? '0 : hpos_q + POS_W'(1);
      if (line_end_c) begin
        vpos_d = frame_end_c ? '0 : vpos_q + POS_W'(1);
      end
      y_d               = Y_W'(vpos_d >> TILE_H_SHIFT);
      sync_d.de         = active_c;
      sync_d.hsync_n    = !in_window(hpos_q, H_ACTIVE + H_FP, H_SYNC);
      sync_d.vsync_n    = !in_window(vpos_q, V_ACTIVE_CFG + V_FP_CFG, V_SYNC_CFG);
      sync_d.frame_tick = frame_end_c;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hpos_q <= '0;
      vpos_q <= '0;
      y_q    <= '0;
      sync_q <= SYNC_IDLE;
    end else begin
      hpos_q <= hpos_d;
      vpos_q <= vpos_d;
      y_q    <= y_d;
      sync_q <= sync_d;
    end
  end

  assign hpos = hpos_q;
  assign y    = y_q;
  assign sync = sync_q;

endmodule

// File: rtl/vga_tile_scanner.sv
// VGA raster source walking the 64x30 tile grid and registering the layer colour onto the pins.
// Define SCAN_SCROLL_EN to add a per-frame horizontal tile scroll.
module vga_tile_scanner
  import vga_timing_pkg::*;
#(
  parameter int unsigned V_ACTIVE_CFG = V_ACTIVE,
  parameter int unsigned V_FP_CFG     = V_FP,
  parameter int unsigned V_SYNC_CFG   = V_SYNC,
  parameter int unsigned V_BP_CFG     = V_BP
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             pix_en,
  output logic [X_W-1:0]   x,
  output logic [Y_W-1:0]   y,
  input  logic [RGB_W-1:0] rgb_in,
  output logic [RGB_W-1:0] vga_rgb,
  output logic             hsync_n,
  output logic             vsync_n,
  output logic             de,
  output logic             frame_tick
);

  logic [POS_W-1:0] hpos;
  sync_t            sync;
  logic             line_end_c;
  logic             active_c;

  logic [TPX_W-1:0] tile_px_q, tile_px_d;
  logic [X_W-1:0]   x_tile_q, x_tile_d;
  rgb222_t          rgb_q, rgb_d;

`ifdef SCAN_SCROLL_EN
  logic             frame_end_c;
  logic [X_W-1:0]   scroll_q, scroll_d;
  logic [X_W-1:0]   x_q, x_d;
`endif

  vga_sync_counter #(
    .V_ACTIVE_CFG (V_ACTIVE_CFG),
    .V_FP_CFG     (V_FP_CFG),
    .V_SYNC_CFG   (V_SYNC_CFG),
    .V_BP_CFG     (V_BP_CFG)
  ) u_sync (
    .clk         (clk),
    .rst_n       (rst_n),
    .pix_en      (pix_en),
    .hpos        (hpos),
    .y           (y),
    .sync        (sync),
    .line_end_c  (line_end_c),
    .active_c    (active_c)
`ifdef SCAN_SCROLL_EN
    ,
    .frame_end_c (frame_end_c)
`endif
  );

  // Tile column walk freezes at the last tile from pixel 639 until the line wraps.
  always_comb begin
    tile_px_d = tile_px_q;
    x_tile_d  = x_tile_q;
    rgb_d     = rgb_q;
    if (pix_en) begin
      if (line_end_c) begin
        tile_px_d = '0;
        x_tile_d  = '0;
      end else if (hpos < POS_W'(H_ACTIVE - 1)) begin
        if (tile_px_q == TPX_W'(TILE_W - 1)) begin
          tile_px_d = '0;
          x_tile_d  = x_tile_q + X_W'(1);
        end else begin
          tile_px_d = tile_px_q + TPX_W'(1);
        end
      end
      rgb_d = active_c ? rgb_in : RGB_BLACK;
    end
  end

`ifdef SCAN_SCROLL_EN
  // Scroll steps on the same edge as the frame wrap, so the new frame's first pixel sees it.
  always_comb begin
    scroll_d = scroll_q;
    x_d      = x_q;
    if (pix_en) begin
      if (frame_end_c) begin
        scroll_d = scroll_q + X_W'(1);
      end
      x_d = x_tile_d + scroll_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      scroll_q <= '0;
      x_q      <= '0;
    end else begin
      scroll_q <= scroll_d;
      x_q      <= x_d;
    end
  end

  assign x = x_q;
`else
  assign x = x_tile_q;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tile_px_q <= '0;
      x_tile_q  <= '0;
      rgb_q     <= RGB_BLACK;
    end else begin
      tile_px_q <= tile_px_d;
      x_tile_q  <= x_tile_d;
      rgb_q     <= rgb_d;
    end
  end

  assign vga_rgb    = rgb_q;
  assign de         = sync.de;
  assign hsync_n    = sync.hsync_n;
  assign vsync_n    = sync.vsync_n;
  assign frame_tick = sync.frame_tick;

endmodule
